// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - alarm ring sequencer: ring/snooze/stop handling, beep cadence, auto-stop
// One event acts per cycle (stop > snooze > tick > match); a button or disarm discards a coincident tick.
module alarm_ring_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int ON_SECS     = 4,
  parameter int OFF_SECS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_armed,
  input  logic       alarm_match,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       melody_en,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt,
  output logic       missed
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam logic [9:0] RING_LIM   = 10'(RING_SECS);
  localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SECS);
  localparam logic [9:0] ON_LIM     = 10'(ON_SECS);
  localparam logic [9:0] OFF_LIM    = 10'(OFF_SECS);
  localparam logic [3:0] MAX_LIM    = 4'(MAX_SNOOZE);
  localparam logic       HAS_OFF    = (OFF_SECS > 0);

  if (RING_SECS < 1 || RING_SECS > 1023) begin : g_bad_ring
    $error("alarm_ring_ctrl: RING_SECS out of range 1..1023");
  end
  if (SNOOZE_SECS < 1 || SNOOZE_SECS > 1023) begin : g_bad_snooze
    $error("alarm_ring_ctrl: SNOOZE_SECS out of range 1..1023");
  end
  if (MAX_SNOOZE < 0 || MAX_SNOOZE > 15) begin : g_bad_max
    $error("alarm_ring_ctrl: MAX_SNOOZE out of range 0..15");
  end
  if (ON_SECS < 1 || ON_SECS > 1023 || OFF_SECS < 0 || OFF_SECS > 1023) begin : g_bad_cadence
    $error("alarm_ring_ctrl: cadence lengths out of range");
  end

  logic [1:0] state_q, state_d;
  logic [9:0] sec_q, sec_d, sec_inc;
  logic [9:0] phase_cnt_q, phase_cnt_d, phase_inc;
  logic       phase_off_q, phase_off_d;
  logic [3:0] snz_d;
  logic       missed_d;

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    phase_cnt_d = phase_cnt_q;
    phase_off_d = phase_off_q;
    snz_d       = snooze_cnt;
    missed_d    = missed;
    sec_inc     = sec_q + 10'd1;
    phase_inc   = phase_cnt_q + 10'd1;

    if (!alarm_armed) begin
      state_d = ST_IDLE;
      snz_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop_btn) begin
            missed_d = 1'b0;
          end else if (alarm_match) begin
            state_d     = ST_RING;
            sec_d       = 10'd0;
            phase_off_d = 1'b0;
            phase_cnt_d = 10'd0;
            missed_d    = 1'b0;
          end
        end
        ST_RING: begin
          if (stop_btn) begin
            state_d = ST_IDLE;
            snz_d   = 4'd0;
          end else if (snooze_btn) begin
            if (snooze_cnt < MAX_LIM) begin
              state_d = ST_SNOOZE;
              snz_d   = snooze_cnt + 4'd1;
              sec_d   = 10'd0;
            end else begin
              state_d = ST_IDLE;
              snz_d   = 4'd0;
            end
          end else if (tick_1hz) begin
            // Limit checked before increment so sec_cnt never wraps.
            if (sec_inc == RING_LIM) begin
              state_d  = ST_IDLE;
              missed_d = 1'b1;
              snz_d    = 4'd0;
            end else begin
              sec_d = sec_inc;
            end
            if (!phase_off_q) begin
              if (phase_inc == ON_LIM) begin
                phase_off_d = HAS_OFF;
                phase_cnt_d = 10'd0;
              end else begin
                phase_cnt_d = phase_inc;
              end
            end else begin
              if (phase_inc == OFF_LIM) begin
                phase_off_d = 1'b0;
                phase_cnt_d = 10'd0;
              end else begin
                phase_cnt_d = phase_inc;
              end
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_btn) begin
            state_d = ST_IDLE;
            snz_d   = 4'd0;
          end else if (!snooze_btn && tick_1hz) begin
            if (sec_inc == SNOOZE_LIM) begin
              state_d     = ST_RING;
              sec_d       = 10'd0;
              phase_off_d = 1'b0;
              phase_cnt_d = 10'd0;
            end else begin
              sec_d = sec_inc;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          snz_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sec_q       <= 10'd0;
      phase_cnt_q <= 10'd0;
      phase_off_q <= 1'b0;
      snooze_cnt  <= 4'd0;
      missed      <= 1'b0;
      melody_en   <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      phase_cnt_q <= phase_cnt_d;
      phase_off_q <= phase_off_d;
      snooze_cnt  <= snz_d;
      missed      <= missed_d;
      melody_en   <= (state_d == ST_RING) && !phase_off_d;
      ringing     <= (state_d == ST_RING);
      snoozing    <= (state_d == ST_SNOOZE);
    end
  end

endmodule
